store_checker: RTL and testbench

STORE_CHECKER -- requirements
Module: store_checker

---
 rtl/store_checker_pkg.sv | 18 +
 rtl/store_checker.sv | 190 +++++++++++++++++++
 tb/tb_store_checker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: FSM states and failure codes.
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ADDR    = 2'd1,
    FC_DATA    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_t;

endpackage

// File: rtl/store_checker.sv
// Watches processor stores against a programmed table of expected (address, data)
// pairs, in order, and reports PASS or the first failing store / timeout.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 4096,
  parameter int SCR_LO  = 80,
  parameter int SCR_HI  = 80
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        memwrite,
  input  logic [AW-1:0]                               dataadr,
  input  logic [DW-1:0]                               writedata,
  input  logic                                        cfg_we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] cfg_idx,
  input  logic [AW-1:0]                               cfg_addr,
  input  logic [DW-1:0]                               cfg_data,
  input  logic [$clog2(DEPTH+1)-1:0]                  cfg_count,
  input  logic                                        start,
  input  logic                                        abort,
  output logic                                        done,
  output logic                                        pass,
  output logic [1:0]                                  fail_code,
  output logic [AW-1:0]                               fail_addr,
  output logic [DW-1:0]                               fail_data,
  output logic [$clog2(DEPTH+1)-1:0]                  match_cnt,
  output logic [$clog2(TIMEOUT+1)-1:0]                cyc_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  state_t          state_r;
  fail_code_t      fail_code_r;
  logic            done_r;
  logic            pass_r;
  logic [AW-1:0]   fail_addr_r;
  logic [DW-1:0]   fail_data_r;
  logic [CW-1:0]   match_cnt_r;
  logic [CW-1:0]   count_r;
  logic [TW-1:0]   cyc_cnt_r;

  logic [AW-1:0]   exp_addr_r [DEPTH];
  logic [DW-1:0]   exp_data_r [DEPTH];

  logic [AW-1:0]   cur_addr_s;
  logic [DW-1:0]   cur_data_s;
  logic [CW-1:0]   count_in_s;
  logic [CW-1:0]   match_next_s;
  logic [TW-1:0]   cyc_next_s;
  logic            scratch_s;
  logic            hit_s;
  logic            final_s;
  logic            data_bad_s;
  logic            addr_bad_s;
  logic            timeout_s;

  // Expected-store table; only writable while no check is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_addr_r[i] <= '0;
        exp_data_r[i] <= '0;
      end
    end else if (cfg_we && (state_r != ST_RUN) && (int'(cfg_idx) < DEPTH)) begin
      exp_addr_r[cfg_idx] <= cfg_addr;
      exp_data_r[cfg_idx] <= cfg_data;
    end
  end

  // Classify the current store against the entry awaiting a match.
  always_comb begin
    cur_addr_s   = exp_addr_r[match_cnt_r[IW-1:0]];
    cur_data_s   = exp_data_r[match_cnt_r[IW-1:0]];
    match_next_s = match_cnt_r + CW'(1);
    count_in_s   = cfg_count;
    scratch_s    = (dataadr >= AW'(SCR_LO)) && (dataadr <= AW'(SCR_HI));
    hit_s        = 1'b0;
    data_bad_s   = 1'b0;
    addr_bad_s   = 1'b0;
    if (cfg_count > CW'(DEPTH)) begin
      count_in_s = CW'(DEPTH);
    end else begin
      count_in_s = cfg_count;
    end
    if (cyc_cnt_r == TW'(TIMEOUT)) begin
      cyc_next_s = cyc_cnt_r;
    end else begin
      cyc_next_s = cyc_cnt_r + TW'(1);
    end
    if (memwrite && (dataadr == cur_addr_s)) begin
      hit_s      = (writedata == cur_data_s);
      data_bad_s = (writedata != cur_data_s);
    end else if (memwrite) begin
      addr_bad_s = !scratch_s;
    end else begin
      hit_s = 1'b0;
    end
    final_s   = hit_s && (match_next_s == count_r);
    timeout_s = (cyc_next_s == TW'(TIMEOUT));
  end

  // Check FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      fail_code_r <= FC_NONE;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
      match_cnt_r <= '0;
      count_r     <= '0;
      cyc_cnt_r   <= '0;
    end else if (abort) begin
      state_r     <= ST_IDLE;
      fail_code_r <= FC_NONE;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
      match_cnt_r <= '0;
      count_r     <= '0;
      cyc_cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            count_r     <= count_in_s;
            match_cnt_r <= '0;
            cyc_cnt_r   <= '0;
            fail_code_r <= FC_NONE;
            fail_addr_r <= '0;
            fail_data_r <= '0;
            if (count_in_s == CW'(0)) begin
              state_r <= ST_PASS;
              done_r  <= 1'b1;
              pass_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              done_r  <= 1'b0;
              pass_r  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          cyc_cnt_r <= cyc_next_s;
          if (hit_s) begin
            match_cnt_r <= match_next_s;
          end
          // A final match beats a timeout landing on the same cycle.
          if (final_s) begin
            state_r <= ST_PASS;
            done_r  <= 1'b1;
            pass_r  <= 1'b1;
          end else if (data_bad_s || addr_bad_s) begin
            state_r     <= ST_FAIL;
            done_r      <= 1'b1;
            fail_code_r <= data_bad_s ? FC_DATA : FC_ADDR;
            fail_addr_r <= dataadr;
            fail_data_r <= writedata;
          end else if (timeout_s) begin
            state_r     <= ST_FAIL;
            done_r      <= 1'b1;
            fail_code_r <= FC_TIMEOUT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_code = fail_code_r;
  assign fail_addr = fail_addr_r;
  assign fail_data = fail_data_r;
  assign match_cnt = match_cnt_r;
  assign cyc_cnt   = cyc_cnt_r;

endmodule

// File: tb/tb_store_checker.sv
// Directed and randomized bench for store_checker, checked against a rule-level model.
module tb_store_checker;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [2:0]  cfg_count = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr;
  logic [31:0] fail_data;
  logic [2:0]  match_cnt;
  logic [4:0]  cyc_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the check as a list of expectations consumed in order.
  logic [31:0] m_ta [DEPTH];
  logic [31:0] m_td [DEPTH];
  bit          m_run, m_done, m_pass;
  int          m_code, m_match, m_count, m_cyc;
  logic [31:0] m_fa, m_fd;

  store_checker #(.DEPTH(DEPTH), .AW(32), .DW(32), .TIMEOUT(TIMEOUT),
                  .SCR_LO(80), .SCR_HI(80)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
    .start(start), .abort(abort), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_addr(fail_addr), .fail_data(fail_data),
    .match_cnt(match_cnt), .cyc_cnt(cyc_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_done = 0; m_pass = 0; m_code = 0;
    m_match = 0; m_count = 0; m_cyc = 0; m_fa = '0; m_fd = '0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_ta[i] = '0;
      m_td[i] = '0;
    end
  endtask

  task automatic model_fail(input int code, input logic [31:0] a, input logic [31:0] d);
    m_run = 0; m_done = 1; m_code = code; m_fa = a; m_fd = d;
  endtask

  task automatic model_edge();
    bit was_run;
    was_run = m_run;
    if (!was_run && cfg_we) begin
      m_ta[cfg_idx] = cfg_addr;
      m_td[cfg_idx] = cfg_data;
    end
    if (abort) begin
      model_clear();
    end else if (was_run) begin
      if (m_cyc < TIMEOUT) m_cyc++;
      if (memwrite) begin
        if (dataadr == m_ta[m_match]) begin
          if (writedata == m_td[m_match]) begin
            m_match++;
            if (m_match == m_count) begin
              m_run = 0; m_done = 1; m_pass = 1;
            end
          end else begin
            model_fail(2, dataadr, writedata);
          end
        end else if (!(dataadr >= 80 && dataadr <= 80)) begin
          model_fail(1, dataadr, writedata);
        end
      end
      if (m_run && m_cyc == TIMEOUT) model_fail(3, '0, '0);
    end else if (start) begin
      m_count = int'(cfg_count); m_match = 0; m_cyc = 0;
      m_code = 0; m_fa = '0; m_fd = '0;
      if (m_count == 0) begin
        m_done = 1; m_pass = 1;
      end else begin
        m_run = 1; m_done = 0; m_pass = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".done"},      32'(done),      32'(m_done));
    check({tag, ".pass"},      32'(pass),      32'(m_pass));
    check({tag, ".fail_code"}, 32'(fail_code), 32'(m_code));
    check({tag, ".fail_addr"}, fail_addr,      m_fa);
    check({tag, ".fail_data"}, fail_data,      m_fd);
    check({tag, ".match_cnt"}, 32'(match_cnt), 32'(m_match));
    check({tag, ".cyc_cnt"},   32'(cyc_cnt),   32'(m_cyc));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    memwrite = 1'b0; cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    step("cfg");
    cfg_we = 1'b0;
  endtask

  task automatic arm(input logic [2:0] cnt);
    cfg_count = cnt; start = 1'b1;
    step("start");
    start = 1'b0;
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step(tag);
    memwrite = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    #13;
    reset = 1'b0;

    // Single-entry pass with a scratch store first.
    write_entry(2'd0, 32'd84, 32'd7);
    arm(3'd1);
    store("scratch", 32'd80, 32'd99);
    check("scratch.done", 32'(done), 32'd0);
    store("pass1", 32'd84, 32'd7);
    check("pass1.pass", 32'(pass), 32'd1);
    check("pass1.match", 32'(match_cnt), 32'd1);

    // Unexpected address.
    arm(3'd1);
    store("badaddr", 32'd88, 32'd5);
    check("badaddr.code", 32'(fail_code), 32'd1);
    check("badaddr.addr", fail_addr, 32'd88);
    check("badaddr.data", fail_data, 32'd5);

    // Data mismatch on the second entry.
    write_entry(2'd1, 32'd92, 32'd3);
    arm(3'd2);
    store("d0", 32'd84, 32'd7);
    store("baddata", 32'd92, 32'd4);
    check("baddata.code", 32'(fail_code), 32'd2);
    check("baddata.match", 32'(match_cnt), 32'd1);
    check("baddata.data", fail_data, 32'd4);

    // Timeout with no stores, then a final match landing on the timeout cycle.
    arm(3'd1);
    for (int i = 0; i < TIMEOUT; i++) step("tmo");
    check("tmo.code", 32'(fail_code), 32'd3);
    check("tmo.cyc", 32'(cyc_cnt), 32'd16);
    arm(3'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) step("late");
    store("late.final", 32'd84, 32'd7);
    check("late.pass", 32'(pass), 32'd1);
    check("late.cyc", 32'(cyc_cnt), 32'd16);

    // Reset mid-run, start with abort, empty check.
    arm(3'd1);
    step("run");
    reset = 1'b1;
    model_reset();
    #1;
    check_all("midreset");
    reset = 1'b0;
    write_entry(2'd0, 32'd84, 32'd7);
    arm(3'd1);
    cfg_count = 3'd1; start = 1'b1; abort = 1'b1;
    step("abort");
    check("abort.done", 32'(done), 32'd0);
    idle_inputs();
    arm(3'd0);
    check("empty.pass", 32'(pass), 32'd1);
    check("empty.match", 32'(match_cnt), 32'd0);

    // Randomized checks with stores biased toward the awaited entry.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < DEPTH; i++)
        write_entry(2'(i), 32'd80 + 32'd4 * 32'($urandom_range(0, 4)), 32'($urandom_range(0, 3)));
      arm(3'($urandom_range(0, 4)));
      for (int c = 0; c < 20; c++) begin
        memwrite = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) begin
          dataadr   = m_ta[m_match % DEPTH];
          writedata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : m_td[m_match % DEPTH];
        end else begin
          dataadr   = 32'd80 + 32'd4 * 32'($urandom_range(0, 4));
          writedata = 32'($urandom_range(0, 3));
        end
        cfg_we   = ($urandom_range(0, 7) == 0);
        cfg_idx  = 2'($urandom_range(0, 3));
        cfg_addr = 32'd80 + 32'd4 * 32'($urandom_range(0, 4));
        cfg_data = 32'($urandom_range(0, 3));
        cfg_count = 3'($urandom_range(0, 4));
        start    = ($urandom_range(0, 15) == 0);
        abort    = ($urandom_range(0, 31) == 0);
        step("rand");
      end
      idle_inputs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
